// File: rtl/serial_word_tx.sv
// Serial word transmitter: shifts a WIDTH-bit word out on sda with a generated sck,
// triggered by a debounced active-low button or a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for trigger, tx_ready high, sck/sda low
// LOW   | sck low, current bit driven on sda
// HIGH  | sck high, sda held for the receiver to sample
// STOP  | sck/sda low for one half-period, then done pulse on return to IDLE
module serial_word_tx #(
   parameter int WIDTH     = 8,
   parameter int CLK_DIV   = 4,
   parameter int DEBOUNCE  = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bbutton,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             sda,
   output logic             sck,
   output logic             busy,
   output logic             done
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE);
   localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
   localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_STOP
   } state_t;

   state_t           state, state_nxt;
   logic [HW-1:0]    half_cnt, half_cnt_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [WIDTH-1:0] shift_reg, shift_reg_nxt;
   logic             sck_nxt, sda_nxt, done_nxt;
   logic             cur_bit;
   logic             trigger;

   logic             sync_1, sync_2;
   logic             db_level;
   logic [DW-1:0]    db_cnt;
   logic             press;

   // Synchroniser flops idle high so a released button never starts a count out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= bbutton;
         sync_2 <= sync_1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_level <= 1'b1;
         db_cnt   <= '0;
         press    <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_level <= sync_2;
            db_cnt   <= '0;
            press    <= db_level & ~sync_2;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end
   end

   assign tx_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign trigger  = (state == ST_IDLE) && (tx_valid || press);

   always_comb begin
      state_nxt     = state;
      half_cnt_nxt  = half_cnt;
      bit_cnt_nxt   = bit_cnt;
      shift_reg_nxt = shift_reg;
      done_nxt      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trigger) begin
               shift_reg_nxt = tx_data;
               bit_cnt_nxt   = '0;
               half_cnt_nxt  = HALF_LOAD;
               state_nxt     = ST_LOW;
            end
         end
         ST_LOW: begin
            if (half_cnt == '0) begin
               half_cnt_nxt = HALF_LOAD;
               state_nxt    = ST_HIGH;
            end else begin
               half_cnt_nxt = half_cnt - HW'(1);
            end
         end
         ST_HIGH: begin
            if (half_cnt == '0) begin
               half_cnt_nxt = HALF_LOAD;
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = ST_STOP;
               end else begin
                  shift_reg_nxt = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
                  bit_cnt_nxt   = bit_cnt + BW'(1);
                  state_nxt     = ST_LOW;
               end
            end else begin
               half_cnt_nxt = half_cnt - HW'(1);
            end
         end
         ST_STOP: begin
            if (half_cnt == '0) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end else begin
               half_cnt_nxt = half_cnt - HW'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next-state view so sda is valid in the first LOW cycle.
   always_comb begin
      cur_bit = MSB_FIRST ? shift_reg_nxt[WIDTH-1] : shift_reg_nxt[0];
      sck_nxt = (state_nxt == ST_HIGH);
      sda_nxt = ((state_nxt == ST_LOW) || (state_nxt == ST_HIGH)) ? cur_bit : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         half_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         sck       <= 1'b0;
         sda       <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         half_cnt  <= half_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift_reg <= shift_reg_nxt;
         sck       <= sck_nxt;
         sda       <= sda_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: an MSB-first and an LSB-first instance checked cycle by cycle
// against arithmetic frame timing derived from WIDTH/CLK_DIV/DEBOUNCE.
module tb_serial_word_tx;

   localparam int W  = 8;
   localparam int C  = 4;
   localparam int DB = 16;
   localparam int L  = 2 * W * C;
   localparam int LAST = (2 * W + 1) * C + 1;

   logic clk, rst_n;
   logic bb0, bb1;
   logic [W-1:0] data0, data1;
   logic valid0, valid1;
   logic rdy0, sda0, sck0, busy0, done0;
   logic rdy1, sda1, sck1, busy1, done1;

   int n_checks = 0;
   int n_pass   = 0;

   serial_word_tx #(.WIDTH(W), .CLK_DIV(C), .DEBOUNCE(DB), .MSB_FIRST(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bbutton(bb0), .tx_data(data0), .tx_valid(valid0),
      .tx_ready(rdy0), .sda(sda0), .sck(sck0), .busy(busy0), .done(done0));

   serial_word_tx #(.WIDTH(W), .CLK_DIV(C), .DEBOUNCE(DB), .MSB_FIRST(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bbutton(bb1), .tx_data(data1), .tx_valid(valid1),
      .tx_ready(rdy1), .sda(sda1), .sck(sck1), .busy(busy1), .done(done1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {busy, sck, sda, done, tx_ready}
   function automatic logic [4:0] obs(input int sel);
      if (sel == 0) return {busy0, sck0, sda0, done0, rdy0};
      return {busy1, sck1, sda1, done1, rdy1};
   endfunction

   // Called at the falling edge of the first cycle after the trigger; returns at the
   // falling edge of the done cycle.
   task automatic check_frame(input string name, input int sel, input logic [W-1:0] word);
      logic [4:0]   o, e;
      logic         prev_sck;
      logic         b;
      logic [W-1:0] recon;
      int           rises, bi;
      bit           msb;
      msb      = (sel == 0);
      prev_sck = 1'b0;
      recon    = '0;
      rises    = 0;
      for (int k = 1; k <= LAST; k++) begin
         o = obs(sel);
         if (k <= L) begin
            bi = (k - 1) / (2 * C);
            b  = msb ? word[W-1-bi] : word[bi];
            e  = {1'b1, 1'(((k - 1) / C) % 2), b, 1'b0, 1'b0};
         end else if (k < LAST) begin
            e = 5'b10000;
         end else begin
            e = 5'b00011;
         end
         n_checks++;
         if (o !== e) $display("FAIL %s cycle %0d busy/sck/sda/done/ready got %b expected %b", name, k, o, e);
         else n_pass++;
         if (o[3] && !prev_sck) begin
            if (rises < W) begin
               if (msb) recon[W-1-rises] = o[2];
               else     recon[rises]     = o[2];
            end
            rises++;
         end
         prev_sck = o[3];
         if (k < LAST) @(negedge clk);
      end
      n_checks++;
      if (rises !== W) $display("FAIL %s_rises got %0d expected %0d", name, rises, W);
      else n_pass++;
      n_checks++;
      if (recon !== word) $display("FAIL %s_word got %h expected %h", name, recon, word);
      else n_pass++;
   endtask

   task automatic check_idle(input string name, input int ncyc);
      int bad;
      bad = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (busy0 || done0 || busy1 || done1) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL %s busy_or_done_cycles got %0d expected 0", name, bad);
      else n_pass++;
   endtask

   task automatic start_hs(input int sel, input logic [W-1:0] word);
      @(negedge clk);
      if (sel == 0) begin valid0 = 1'b1; data0 = word; end
      else          begin valid1 = 1'b1; data1 = word; end
      @(negedge clk);
      valid0 = 1'b0;
      valid1 = 1'b0;
      data0  = W'($urandom);
      data1  = W'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (obs(0) !== 5'b00001) $display("FAIL reset_dut0 got %b expected 00001", obs(0));
      else n_pass++;
      n_checks++;
      if (obs(1) !== 5'b00001) $display("FAIL reset_dut1 got %b expected 00001", obs(1));
      else n_pass++;
      rst_n = 1'b1;
      check_idle("after_reset", 5);
   endtask

   task automatic test_msb_first();
      start_hs(0, 8'hA5);
      check_frame("msb_a5", 0, 8'hA5);
   endtask

   task automatic test_lsb_first();
      start_hs(1, 8'h01);
      check_frame("lsb_01", 1, 8'h01);
   endtask

   task automatic test_random_words();
      logic [W-1:0] w;
      for (int i = 0; i < 4; i++) begin
         w = W'($urandom);
         start_hs(i % 2, w);
         check_frame($sformatf("rand%0d", i), i % 2, w);
      end
   endtask

   task automatic test_debounce();
      logic [W-1:0] w;
      int early;
      @(negedge clk);
      bb0 = 1'b0;
      repeat (10) @(negedge clk);
      bb0 = 1'b1;
      check_idle("glitch", 40);
      w = W'($urandom);
      data0 = w;
      bb0 = 1'b0;
      early = 0;
      for (int c = 1; c <= 2 + DB; c++) begin
         @(negedge clk);
         if (busy0) early++;
      end
      n_checks++;
      if (early !== 0) $display("FAIL press_latency early_busy_cycles got %0d expected 0", early);
      else n_pass++;
      @(negedge clk);
      check_frame("button", 0, w);
      bb0 = 1'b1;
      check_idle("release", 60);
   endtask

   task automatic test_busy_press();
      logic [W-1:0] w;
      w = W'($urandom);
      start_hs(0, w);
      fork
         check_frame("press_busy", 0, w);
         begin
            bb0 = 1'b0;
            repeat (30) @(negedge clk);
            bb0 = 1'b1;
         end
      join
      check_idle("press_busy_after", 60);
   endtask

   task automatic test_coincident();
      logic [W-1:0] w;
      w = W'($urandom);
      @(negedge clk);
      bb0 = 1'b0;
      repeat (1 + DB) @(negedge clk);
      valid0 = 1'b1;
      data0  = w;
      @(negedge clk);
      valid0 = 1'b0;
      check_frame("coincident", 0, w);
      bb0 = 1'b1;
      check_idle("coincident_after", 60);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      valid0 = 1'b1;
      data0  = 8'h3C;
      @(negedge clk);
      data0 = 8'hC3;
      check_frame("b2b_first", 0, 8'h3C);
      @(negedge clk);
      valid0 = 1'b0;
      check_frame("b2b_second", 0, 8'hC3);
      check_idle("b2b_after", 20);
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] w;
      logic [4:0]   o;
      w = W'($urandom);
      start_hs(0, w);
      repeat (29) @(negedge clk);
      n_checks++;
      if (sck0 !== 1'b1) $display("FAIL pre_reset_sck got %b expected 1", sck0);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      o = obs(0);
      n_checks++;
      if (o !== 5'b00001) $display("FAIL reset_mid_async got %b expected 00001", o);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_idle("reset_mid_after", 80);
      w = W'($urandom);
      start_hs(0, w);
      check_frame("post_reset", 0, w);
   endtask

   initial begin
      rst_n  = 1'b0;
      bb0    = 1'b1;
      bb1    = 1'b1;
      valid0 = 1'b0;
      valid1 = 1'b0;
      data0  = '0;
      data1  = '0;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_random_words();
      test_debounce();
      test_busy_press();
      test_coincident();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
